// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TileLink-UL field widths, opcodes and beat structs
//
// Purpose: shared definitions for the TL-UL buffer slice. Fixed field widths,
// A/D opcode constants and the packed A/D channel beat types.
// Ports: none (package).

package tl_ul_pkg;

  localparam int ADDR_W    = 15;
  localparam int SRC_W     = 1;
  localparam int DATA_W    = 32;
  localparam int MASK_W    = DATA_W / 8;
  localparam int OP_W      = 3;
  localparam int A_PARAM_W = 3;
  localparam int D_PARAM_W = 2;
  localparam int SIZE_W    = 2;

  // A-channel opcodes
  localparam logic [OP_W-1:0] OP_PUT_FULL_DATA    = 3'd0;
  localparam logic [OP_W-1:0] OP_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [OP_W-1:0] OP_GET              = 3'd4;

  // D-channel opcodes
  localparam logic [OP_W-1:0] OP_ACCESS_ACK       = 3'd0;
  localparam logic [OP_W-1:0] OP_ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [OP_W-1:0]      opcode;
    logic [A_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SRC_W-1:0]     source;
    logic [ADDR_W-1:0]    address;
    logic [MASK_W-1:0]    mask;
    logic [DATA_W-1:0]    data;
  } tl_a_t;

  typedef struct packed {
    logic [OP_W-1:0]      opcode;
    logic [D_PARAM_W-1:0] param;
    logic [SIZE_W-1:0]    size;
    logic [SRC_W-1:0]     source;
    logic                 denied;
    logic [DATA_W-1:0]    data;
    logic                 corrupt;
  } tl_d_t;

  localparam int A_W = $bits(tl_a_t);
  localparam int D_W = $bits(tl_d_t);

endpackage

// File: rtl/tl_ul_fifo.sv
// rtl/tl_ul_fifo.sv - count-based FIFO with registered ready and flop-array storage
//
// Purpose: one channel of the TL-UL buffer. Holds up to DEPTH beats; a beat
// pushed in cycle N is visible at the output in cycle N+1 (no bypass).
// Ports:
//   clock, reset_n             clock and asynchronous active-low reset
//   in_valid/in_ready/in_data  write side; in_ready is a flop, low in reset
//   out_valid/out_ready/out_data  read side; out_data is the head entry

module tl_ul_fifo
  import tl_ul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      // Ready is computed from next-state count so it never depends on the
      // current cycle's valid inputs.
      in_ready <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/tl_ul_buffer.sv
// rtl/tl_ul_buffer.sv - registered TL-UL buffer with inflight cap and unexpected-D flag
//
// Purpose: decouples A and D channel timing between core and interconnect,
// limits outstanding A requests to MAX_INFLIGHT and flags any D response
// accepted while nothing is outstanding.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   up_a_valid/up_a_ready/up_a     A channel from the core
//   dn_a_valid/dn_a_ready/dn_a     A channel to the interconnect
//   dn_d_valid/dn_d_ready/dn_d     D channel from the interconnect
//   up_d_valid/up_d_ready/up_d     D channel to the core
//   inflight                       outstanding request count
//   err_unexp_d                    sticky: D accepted with nothing in flight

module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 2,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          up_a_valid,
  output logic          up_a_ready,
  input  tl_a_t         up_a,
  output logic          dn_a_valid,
  input  logic          dn_a_ready,
  output tl_a_t         dn_a,
  input  logic          dn_d_valid,
  output logic          dn_d_ready,
  input  tl_d_t         dn_d,
  output logic          up_d_valid,
  input  logic          up_d_ready,
  output tl_d_t         up_d,
  output logic [IW-1:0] inflight,
  output logic          err_unexp_d
);

  logic          a_head_valid;
  logic          a_head_ready;
  logic          cap_ok;
  logic          a_fire;
  logic          d_fire;
  logic [IW-1:0] inflight_q;
  logic [IW-1:0] inflight_nxt;
  logic          err_q;
  logic          err_nxt;

  // A beats are held in the FIFO head while the cap is reached, which keeps
  // dn_a stable until the beat can be issued.
  assign cap_ok       = (inflight_q < IW'(MAX_INFLIGHT));
  assign dn_a_valid   = a_head_valid && cap_ok;
  assign a_head_ready = dn_a_ready && cap_ok;
  assign a_fire       = dn_a_valid && dn_a_ready;
  assign d_fire       = dn_d_valid && dn_d_ready;

  tl_ul_fifo #(
    .WIDTH (A_W),
    .DEPTH (DEPTH)
  ) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (up_a_valid),
    .in_ready  (up_a_ready),
    .in_data   (up_a),
    .out_valid (a_head_valid),
    .out_ready (a_head_ready),
    .out_data  (dn_a)
  );

  tl_ul_fifo #(
    .WIDTH (D_W),
    .DEPTH (DEPTH)
  ) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (dn_d_valid),
    .in_ready  (dn_d_ready),
    .in_data   (dn_d),
    .out_valid (up_d_valid),
    .out_ready (up_d_ready),
    .out_data  (up_d)
  );

  // A D fire with nothing outstanding is an interconnect protocol error: the
  // count is held at zero rather than wrapping, and the beat still passes.
  always_comb begin
    inflight_nxt = inflight_q;
    err_nxt      = err_q;
    if (d_fire && (inflight_q == '0)) begin
      err_nxt = 1'b1;
    end
    if (a_fire && !d_fire) begin
      inflight_nxt = inflight_q + IW'(1);
    end else if (d_fire && !a_fire && (inflight_q != '0)) begin
      inflight_nxt = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_nxt;
      err_q      <= err_nxt;
    end
  end

  assign inflight    = inflight_q;
  assign err_unexp_d = err_q;

endmodule

// File: tb/tb_tl_ul_buffer.sv
// tb/tb_tl_ul_buffer.sv - directed scoreboard bench for tl_ul_buffer

module tb_tl_ul_buffer;
  import tl_ul_pkg::*;

  localparam int MAX_INF = 2;
  localparam int IW      = $clog2(MAX_INF + 1);

  logic          clock;
  logic          reset_n;
  logic          up_a_valid;
  logic          up_a_ready;
  tl_a_t         up_a;
  logic          dn_a_valid;
  logic          dn_a_ready;
  tl_a_t         dn_a;
  logic          dn_d_valid;
  logic          dn_d_ready;
  tl_d_t         dn_d;
  logic          up_d_valid;
  logic          up_d_ready;
  tl_d_t         up_d;
  logic [IW-1:0] inflight;
  logic          err_unexp_d;

  int checks   = 0;
  int failures = 0;

  tl_a_t exp_a[$];
  tl_d_t exp_d[$];
  int    m_inflight = 0;
  logic  m_err      = 1'b0;
  logic  prev_av    = 1'b0;
  logic  prev_dv    = 1'b0;
  tl_a_t prev_a;
  tl_d_t prev_d;

  tl_ul_buffer #(
    .DEPTH        (2),
    .MAX_INFLIGHT (MAX_INF)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .up_a_valid  (up_a_valid),
    .up_a_ready  (up_a_ready),
    .up_a        (up_a),
    .dn_a_valid  (dn_a_valid),
    .dn_a_ready  (dn_a_ready),
    .dn_a        (dn_a),
    .dn_d_valid  (dn_d_valid),
    .dn_d_ready  (dn_d_ready),
    .dn_d        (dn_d),
    .up_d_valid  (up_d_valid),
    .up_d_ready  (up_d_ready),
    .up_d        (up_d),
    .inflight    (inflight),
    .err_unexp_d (err_unexp_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic tl_a_t mk_a(input logic [2:0] op, input logic [14:0] addr,
                                 input logic [3:0] mask, input logic [31:0] data);
    tl_a_t b;
    b.opcode  = op;
    b.param   = '0;
    b.size    = 2'd2;
    b.source  = '0;
    b.address = addr;
    b.mask    = mask;
    b.data    = data;
    return b;
  endfunction

  function automatic tl_d_t mk_d(input logic [2:0] op, input logic [31:0] data);
    tl_d_t b;
    b.opcode  = op;
    b.param   = '0;
    b.size    = 2'd2;
    b.source  = '0;
    b.denied  = 1'b0;
    b.data    = data;
    b.corrupt = 1'b0;
    return b;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard and reference inflight/error model, sampled mid-cycle.
  always @(negedge clock) begin
    logic a_in, a_out, d_in, d_out;
    if (!reset_n) begin
      exp_a.delete();
      exp_d.delete();
      m_inflight = 0;
      m_err      = 1'b0;
      prev_av    = 1'b0;
      prev_dv    = 1'b0;
    end else begin
      chk("inflight_model", 64'(inflight), 64'(m_inflight));
      chk("err_model", 64'(err_unexp_d), 64'(m_err));
      if (dn_a_valid) chk("cap_respected", 64'(m_inflight < MAX_INF), 64'(1));
      if (prev_av) begin
        chk("dn_a_valid_hold", 64'(dn_a_valid), 64'(1));
        chk("dn_a_stable", 64'(dn_a), 64'(prev_a));
      end
      if (prev_dv) begin
        chk("up_d_valid_hold", 64'(up_d_valid), 64'(1));
        chk("up_d_stable", 64'(up_d), 64'(prev_d));
      end
      a_in  = up_a_valid && up_a_ready;
      a_out = dn_a_valid && dn_a_ready;
      d_in  = dn_d_valid && dn_d_ready;
      d_out = up_d_valid && up_d_ready;
      if (a_out) begin
        if (exp_a.size() == 0) chk("dn_a_unexpected_beat", 64'(1), 64'(0));
        else chk("dn_a_beat", 64'(dn_a), 64'(exp_a.pop_front()));
      end
      if (d_out) begin
        if (exp_d.size() == 0) chk("up_d_unexpected_beat", 64'(1), 64'(0));
        else chk("up_d_beat", 64'(up_d), 64'(exp_d.pop_front()));
      end
      if (a_in) exp_a.push_back(up_a);
      if (d_in) exp_d.push_back(dn_d);
      if (d_in && m_inflight == 0) m_err = 1'b1;
      if (a_out && !d_in) m_inflight++;
      else if (d_in && !a_out && m_inflight > 0) m_inflight--;
      prev_av = dn_a_valid && !a_out;
      prev_a  = dn_a;
      prev_dv = up_d_valid && !d_out;
      prev_d  = up_d;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    tl_a_t b0, b1, b2;
    reset_n    = 1'b0;
    up_a_valid = 1'b0;
    dn_a_ready = 1'b0;
    dn_d_valid = 1'b0;
    up_d_ready = 1'b0;
    up_a       = '0;
    dn_d       = '0;
    repeat (3) @(posedge clock);
    #1;
    // reset state
    chk("rst_up_a_ready", 64'(up_a_ready), 64'(0));
    chk("rst_dn_d_ready", 64'(dn_d_ready), 64'(0));
    chk("rst_dn_a_valid", 64'(dn_a_valid), 64'(0));
    chk("rst_up_d_valid", 64'(up_d_valid), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    chk("rst_err", 64'(err_unexp_d), 64'(0));
    chk("rst_dn_a", 64'(dn_a), 64'(0));
    chk("rst_up_d", 64'(up_d), 64'(0));
    reset_n = 1'b1;
    tick;
    chk("post_rst_up_a_ready", 64'(up_a_ready), 64'(1));
    chk("post_rst_dn_d_ready", 64'(dn_d_ready), 64'(1));

    // single Get round trip
    dn_a_ready = 1'b1;
    up_d_ready = 1'b1;
    up_a       = mk_a(OP_GET, 15'h1234, 4'hf, 32'h0);
    up_a_valid = 1'b1;
    chk("get_no_bypass", 64'(dn_a_valid), 64'(0));
    tick;
    up_a_valid = 1'b0;
    chk("get_dn_a_valid", 64'(dn_a_valid), 64'(1));
    chk("get_addr", 64'(dn_a.address), 64'h1234);
    chk("get_opcode", 64'(dn_a.opcode), 64'(OP_GET));
    chk("get_inflight0", 64'(inflight), 64'(0));
    tick;
    chk("get_dn_a_gone", 64'(dn_a_valid), 64'(0));
    chk("get_inflight1", 64'(inflight), 64'(1));
    dn_d       = mk_d(OP_ACCESS_ACK_DATA, 32'hDEADBEEF);
    dn_d_valid = 1'b1;
    chk("ack_no_bypass", 64'(up_d_valid), 64'(0));
    tick;
    dn_d_valid = 1'b0;
    chk("ack_up_d_valid", 64'(up_d_valid), 64'(1));
    chk("ack_data", 64'(up_d.data), 64'h0DEADBEEF);
    chk("ack_inflight0", 64'(inflight), 64'(0));
    tick;
    chk("ack_drained", 64'(up_d_valid), 64'(0));

    // A FIFO fill with downstream stalled, then the inflight cap
    b0 = mk_a(OP_PUT_FULL_DATA, 15'h0100, 4'hf, 32'h11111111);
    b1 = mk_a(OP_PUT_PARTIAL_DATA, 15'h0104, 4'h3, 32'h22222222);
    b2 = mk_a(OP_GET, 15'h0108, 4'hf, 32'h0);
    dn_a_ready = 1'b0;
    up_a       = b0;
    up_a_valid = 1'b1;
    chk("fill_ready0", 64'(up_a_ready), 64'(1));
    tick;
    up_a = b1;
    chk("fill_ready1", 64'(up_a_ready), 64'(1));
    chk("fill_head_valid", 64'(dn_a_valid), 64'(1));
    tick;
    up_a = b2;
    chk("fill_full", 64'(up_a_ready), 64'(0));
    tick;
    chk("fill_still_full", 64'(up_a_ready), 64'(0));
    chk("fill_head_b0", 64'(dn_a), 64'(b0));
    dn_a_ready = 1'b1;
    tick;
    chk("ready_returns", 64'(up_a_ready), 64'(1));
    chk("head_b1", 64'(dn_a), 64'(b1));
    chk("inflight_after_b0", 64'(inflight), 64'(1));
    tick;
    up_a_valid = 1'b0;
    chk("cap_inflight2", 64'(inflight), 64'(2));
    chk("cap_held", 64'(dn_a_valid), 64'(0));
    tick;
    chk("cap_still_held", 64'(dn_a_valid), 64'(0));
    chk("cap_head_b2", 64'(dn_a), 64'(b2));
    dn_d       = mk_d(OP_ACCESS_ACK, 32'h0);
    dn_d_valid = 1'b1;
    tick;
    dn_d_valid = 1'b0;
    chk("cap_released", 64'(dn_a_valid), 64'(1));
    chk("cap_inflight1", 64'(inflight), 64'(1));
    tick;
    chk("b2_issued", 64'(inflight), 64'(2));
    dn_d       = mk_d(OP_ACCESS_ACK, 32'h1);
    dn_d_valid = 1'b1;
    tick;
    dn_d = mk_d(OP_ACCESS_ACK_DATA, 32'hCAFE0002);
    tick;
    dn_d_valid = 1'b0;
    chk("cap_drained", 64'(inflight), 64'(0));
    tick;
    tick;

    // simultaneous A and D fire with one outstanding
    up_a       = mk_a(OP_GET, 15'h0200, 4'hf, 32'h0);
    up_a_valid = 1'b1;
    tick;
    up_a = mk_a(OP_PUT_FULL_DATA, 15'h0204, 4'hf, 32'h33333333);
    tick;
    up_a_valid = 1'b0;
    chk("sim_inflight_pre", 64'(inflight), 64'(1));
    chk("sim_a_valid", 64'(dn_a_valid), 64'(1));
    dn_d       = mk_d(OP_ACCESS_ACK_DATA, 32'h44444444);
    dn_d_valid = 1'b1;
    tick;
    chk("sim_inflight_hold", 64'(inflight), 64'(1));
    chk("sim_no_err", 64'(err_unexp_d), 64'(0));
    dn_d = mk_d(OP_ACCESS_ACK, 32'h0);
    tick;
    dn_d_valid = 1'b0;
    chk("sim_inflight_done", 64'(inflight), 64'(0));
    tick;

    // unexpected D with nothing outstanding
    dn_d       = mk_d(OP_ACCESS_ACK_DATA, 32'h5A5A5A5A);
    dn_d_valid = 1'b1;
    chk("unexp_err_pre", 64'(err_unexp_d), 64'(0));
    tick;
    dn_d_valid = 1'b0;
    chk("unexp_err_set", 64'(err_unexp_d), 64'(1));
    chk("unexp_inflight0", 64'(inflight), 64'(0));
    chk("unexp_delivered", 64'(up_d_valid), 64'(1));
    chk("unexp_data", 64'(up_d.data), 64'h05A5A5A5A);
    tick;
    tick;
    chk("unexp_sticky", 64'(err_unexp_d), 64'(1));

    // reset with both FIFOs holding two beats
    dn_a_ready = 1'b0;
    up_d_ready = 1'b0;
    up_a       = mk_a(OP_GET, 15'h0300, 4'hf, 32'h0);
    up_a_valid = 1'b1;
    tick;
    up_a = mk_a(OP_GET, 15'h0304, 4'hf, 32'h0);
    tick;
    up_a_valid = 1'b0;
    dn_d       = mk_d(OP_ACCESS_ACK, 32'h6);
    dn_d_valid = 1'b1;
    tick;
    dn_d = mk_d(OP_ACCESS_ACK, 32'h7);
    tick;
    dn_d_valid = 1'b0;
    chk("pre_rst_a_full", 64'(up_a_ready), 64'(0));
    chk("pre_rst_d_full", 64'(dn_d_ready), 64'(0));
    chk("pre_rst_a_valid", 64'(dn_a_valid), 64'(1));
    chk("pre_rst_d_valid", 64'(up_d_valid), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 64'(dn_a_valid), 64'(0));
    chk("mid_rst_d_valid", 64'(up_d_valid), 64'(0));
    chk("mid_rst_inflight", 64'(inflight), 64'(0));
    chk("mid_rst_err", 64'(err_unexp_d), 64'(0));
    chk("mid_rst_up_a_ready", 64'(up_a_ready), 64'(0));
    chk("mid_rst_dn_d_ready", 64'(dn_d_ready), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset_n    = 1'b1;
    dn_a_ready = 1'b1;
    up_d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_rst_quiet_a", 64'(dn_a_valid), 64'(0));
      chk("post_rst_quiet_d", 64'(up_d_valid), 64'(0));
    end

    // fresh transaction after reset
    up_a       = mk_a(OP_GET, 15'h7FFC, 4'hf, 32'h0);
    up_a_valid = 1'b1;
    tick;
    up_a_valid = 1'b0;
    tick;
    chk("final_inflight", 64'(inflight), 64'(1));
    dn_d       = mk_d(OP_ACCESS_ACK_DATA, 32'h89ABCDEF);
    dn_d_valid = 1'b1;
    tick;
    dn_d_valid = 1'b0;
    tick;
    tick;
    chk("final_err_clear", 64'(err_unexp_d), 64'(0));
    chk("sb_a_empty", 64'(exp_a.size()), 64'(0));
    chk("sb_d_empty", 64'(exp_d.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
